// File: rtl/calc1_pkg.sv
// Shared codes, widths and state encoding for the calc1 port responder.
package calc1_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPND2 = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Response payload as it leaves the port.
    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 arithmetic: add/sub with overflow/underflow detect, logical shifts.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [RESP_W-1:0] resp_c,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W:0]    sum;
    logic [SHAMT_W-1:0] shamt;

    // Any path that does not explicitly succeed reports an error with zero data.
    always_comb begin
        sum      = {1'b0, op1} + {1'b0, op2};
        shamt    = op2[SHAMT_W-1:0];
        resp_c   = RESP_ERR;
        result_c = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp_c   = RESP_OK;
                    result_c = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp_c   = RESP_OK;
                    result_c = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp_c   = RESP_OK;
                result_c = op1 << shamt;
            end
            CMD_SHR: begin
                resp_c   = RESP_OK;
                result_c = op1 >> shamt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: two-cycle cmd/operand capture, fixed latency, one-cycle response.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [RESP_W-1:0] out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    // EXEC counts down from LATENCY-1 and leaves when the count is already zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [RESP_W-1:0] resp_d;
    logic [DATA_W-1:0] data_d;
    logic              busy_d;

    logic [DATA_W-1:0] alu_op2;
    logic [RESP_W-1:0] alu_resp;
    logic [DATA_W-1:0] alu_result;

    // With LATENCY = 1 the result is registered in the operand-2 cycle, so bypass the latch.
    assign alu_op2 = (state_q == ST_OPND2) ? req_data_in : op2_q;

    calc1_alu #(
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .cmd      (cmd_q),
        .op1      (op1_q),
        .op2      (alu_op2),
        .resp_c   (alu_resp),
        .result_c (alu_result)
    );

    // Next-state, latch-enable and output-next logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = RESP_NONE;
        data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != CMD_NOP) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                op2_d = req_data_in;
                cnt_d = CNT_LOAD;
                if (CNT_LOAD == '0) begin
                    state_d = ST_RESP;
                    resp_d  = alu_resp;
                    data_d  = alu_result;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    resp_d  = alu_resp;
                    data_d  = alu_result;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, latches and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            out_resp <= resp_d;
            out_data <= data_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Scoreboard bench for calc1_port_responder at LATENCY = 3.
module tb_calc1_port_responder;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];

    calc1_port_responder #(
        .LATENCY (3),
        .SHAMT_W (5)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;

    // Every non-zero response must match the oldest expected entry.
    always @(negedge c_clk) begin
        logic [33:0] e;
        if (reset === 1'b1 && out_resp !== 2'd0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got resp=%0d data=%h, required no response", out_resp, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_resp, out_data} !== e) begin
                    bad++;
                    $display("FAIL scoreboard: got resp=%0d data=%h, required resp=%0d data=%h",
                             out_resp, out_data, e[33:32], e[31:0]);
                end
            end
        end
    end

    // Bail out if the run stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives cmd/op1 then op2, starting just after a rising edge; returns 1ns after the op2 edge.
    task automatic drive_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        req_cmd_in  = cmd;
        req_data_in = a;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = b;
        @(posedge c_clk); #1;
        req_data_in = 32'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge c_clk);
            n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge c_clk); #1;
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
        exp_q.push_back({er, ed});
        drive_op(cmd, a, b);
        drain();
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        req_cmd_in  = 4'd1;
        req_data_in = 32'h1234_5678;
        repeat (3) @(posedge c_clk);
        #1;
        total++;
        if ({out_resp, out_data, busy} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got resp=%0d data=%h busy=%b, required 0/0/0", out_resp, out_data, busy);
        end
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        reset = 1'b1;
        @(posedge c_clk); #1;
        total++;
        if ({out_resp, busy} !== 3'd0) begin
            bad++;
            $display("FAIL after_release: got resp=%0d busy=%b, required 0/0", out_resp, busy);
        end
    endtask

    task automatic test_add_timing();
        logic [1:0] er;
        exp_q.push_back({2'd1, 32'h2000_0000});
        drive_op(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge c_clk);
            er = (i == 4) ? 2'd1 : 2'd0;
            total++;
            if (out_resp !== er || busy !== (i <= 4)) begin
                bad++;
                $display("FAIL add_timing[%0d]: got resp=%0d busy=%b, required resp=%0d busy=%b",
                         i, out_resp, busy, er, (i <= 4));
            end
            if (i == 4) begin
                total++;
                if (out_data !== 32'h2000_0000) begin
                    bad++;
                    $display("FAIL add_data: got %h, required 20000000", out_data);
                end
            end
        end
        drain();
    endtask

    task automatic test_overflow();
        send(4'd1, 32'hFFFF_FFFF, 32'h1,        2'd2, 32'h0);
        send(4'd1, 32'hFFFF_FFFE, 32'h1,        2'd1, 32'hFFFF_FFFF);
        send(4'd2, 32'h1,         32'hF,        2'd2, 32'h0);
        send(4'd2, 32'h5,         32'h5,        2'd1, 32'h0);
        send(4'd2, 32'h6,         32'h5,        2'd1, 32'h1);
        send(4'd2, 32'h1234_0000, 32'h0000_1234, 2'd1, 32'h1233_EDCC);
    endtask

    task automatic test_shifts();
        logic [31:0] a, b;
        send(4'd5, 32'h0000_0001, 32'h1,         2'd1, 32'h0000_0002);
        send(4'd6, 32'h8000_0000, 32'h1,         2'd1, 32'h4000_0000);
        send(4'd5, 32'h0000_0001, 32'hFFFF_FFE3, 2'd1, 32'h0000_0008);
        send(4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 2'd1, 32'hDEAD_BEEF);
        for (int i = 0; i < 32; i++) begin
            a = 32'h1 << i;
            b = {$urandom_range(0, 32'h07FF_FFFF), 5'(i ^ 7)};
            send(4'd5, a, b, 2'd1, a << b[4:0]);
            b = {$urandom_range(0, 32'h07FF_FFFF), 5'(31 - i)};
            send(4'd6, a, b, 2'd1, a >> b[4:0]);
        end
    endtask

    task automatic test_invalid();
        send(4'd3,  32'h1, 32'h2,          2'd2, 32'h0);
        send(4'd4,  32'h1, 32'h0,          2'd2, 32'h0);
        send(4'd7,  32'h1, 32'h1,          2'd2, 32'h0);
        send(4'd15, 32'h1, $urandom(),     2'd2, 32'h0);
    endtask

    task automatic test_noop();
        for (int i = 0; i < 20; i++) begin
            req_cmd_in  = 4'd0;
            req_data_in = $urandom();
            @(negedge c_clk);
            total++;
            if ({out_resp, out_data, busy} !== 35'd0) begin
                bad++;
                $display("FAIL noop[%0d]: got resp=%0d data=%h busy=%b, required 0/0/0",
                         i, out_resp, out_data, busy);
            end
            @(posedge c_clk); #1;
        end
        req_data_in = 32'd0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        exp_q.push_back({2'd1, 32'd5});
        drive_op(4'd1, 32'd2, 32'd3);
        req_cmd_in  = 4'd1;
        req_data_in = 32'd7;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd7;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_exec: got %b, required 1", busy);
        end
        @(posedge c_clk); #1;
        req_data_in = 32'd0;
        @(negedge c_clk);
        while (out_resp === 2'd0 && n < 20) begin
            @(negedge c_clk);
            n++;
        end
        total++;
        if (out_resp === 2'd0) begin
            bad++;
            $display("FAIL busy_drop_wait: got no response in 20 cycles, required one");
        end
        // RESP cycle: this command must be dropped.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd9;
        @(posedge c_clk); #1;
        // First IDLE cycle: this one must be accepted.
        exp_q.push_back({2'd1, 32'd8});
        req_data_in = 32'd4;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd4;
        @(posedge c_clk); #1;
        req_data_in = 32'd0;
        drain();
    endtask

    task automatic test_reset_mid();
        drive_op(4'd1, 32'd1, 32'd1);
        @(negedge c_clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_before_reset: got %b, required 1", busy);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({out_resp, out_data, busy} !== 35'd0) begin
            bad++;
            $display("FAIL reset_mid: got resp=%0d data=%h busy=%b, required 0/0/0", out_resp, out_data, busy);
        end
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge c_clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b, required 0", busy);
        end
        send(4'd1, 32'd1, 32'd1, 2'd1, 32'd2);
    endtask

    initial begin
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        test_reset();
        test_add_timing();
        test_overflow();
        test_shifts();
        test_invalid();
        test_noop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
